// File: rtl/fwd_source_tracker.sv
// Producer-side operand-forwarding tracker: shadows EX/MEM/WB destination info,
// flags load-use hazards and counts the stall cycles they cost.
module fwd_source_tracker #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pipe_en,
   input  logic             flush_ex,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rw,
   input  logic             id_regwen,
   input  logic             id_memread,
   output logic [REG_W-1:0] rwMEM,
   output logic [REG_W-1:0] rwWB,
   output logic             regWENmem,
   output logic             regWENwb,
   output logic             load_stall,
   output logic [31:0]      busy_mask,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic             valid;
      logic             wen;
      logic             ld;
      logic [REG_W-1:0] rw;
   } stage_t;

   stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // flush_ex masks the hazard so a killed consumer never costs a stall cycle
   always_comb begin
      load_stall = id_valid & ~flush_ex & ex_q.valid & ex_q.wen & ex_q.ld &
                   ((ex_q.rw == id_rs) | (ex_q.rw == id_rt));
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (pipe_en) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (flush_ex | load_stall | ~id_valid) begin
            ex_d = '0;
         end else begin
            ex_d.valid = 1'b1;
            ex_d.rw    = id_rw;
            ex_d.wen   = id_regwen & (id_rw != '0);
            ex_d.ld    = id_memread;
         end
         if (load_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         if ((ex_q.valid  & ex_q.wen  & (ex_q.rw  == REG_W'(r))) |
             (mem_q.valid & mem_q.wen & (mem_q.rw == REG_W'(r))) |
             (wb_q.valid  & wb_q.wen  & (wb_q.rw  == REG_W'(r)))) begin
            busy_mask[r] = 1'b1;
         end
      end
   end

   assign rwMEM     = mem_q.rw;
   assign rwWB      = wb_q.rw;
   assign regWENmem = mem_q.valid & mem_q.wen;
   assign regWENwb  = wb_q.valid & wb_q.wen;
   assign stall_cnt = cnt_q;

endmodule
